// File: rtl/pixel_block_buffer_pkg.sv
// Shared defaults, error-bit indices and a constant clog2 for the pixel block buffer slice.
package pixel_block_buffer_pkg;

    localparam int unsigned DefPixW   = 8;
    localparam int unsigned DefBlkDim = 8;
    localparam int unsigned DefWordW  = 32;

    localparam int unsigned ErrSobDrop  = 0;
    localparam int unsigned ErrAckEmpty = 1;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/pixel_block_buffer_word_assembler.sv
// Packs PPW pixels MSB-first into one line word; word_done_o strobes on the last pixel of a word.
module pixel_word_assembler
    import pixel_block_buffer_pkg::*;
#(
    parameter int unsigned PIX_W = DefPixW,
    parameter int unsigned PPW   = DefWordW / DefPixW,
    localparam int unsigned WORD_W = PIX_W * PPW,
    localparam int unsigned CW     = (PPW > 1) ? clog2(PPW) : 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              shift_i,
    input  logic              restart_i,
    input  logic [PIX_W-1:0]  pix_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_done_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_eff;

    // A restart makes the incoming pixel the first of a fresh word.
    assign cnt_eff     = restart_i ? '0 : cnt_q;
    assign word_done_o = shift_i & (cnt_eff == CW'(PPW - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (shift_i) begin
            cnt_q <= word_done_o ? '0 : cnt_eff + 1'b1;
        end
    end

    if (PPW == 1) begin : g_single
        assign word_o = pix_i;
    end else begin : g_multi
        logic [WORD_W-PIX_W-1:0] asm_q;

        assign word_o = {asm_q, pix_i};

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                asm_q <= '0;
            end else if (shift_i) begin
                asm_q <= word_o[WORD_W-PIX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pixel_block_buffer.sv
// Double-buffered pixel block buffer: raster pixels in, packed block words read out by address.
module pixel_block_buffer
    import pixel_block_buffer_pkg::*;
#(
    parameter int unsigned PIX_W   = DefPixW,
    parameter int unsigned BLK_DIM = DefBlkDim,
    parameter int unsigned WORD_W  = DefWordW,
    localparam int unsigned PPW  = WORD_W / PIX_W,
    localparam int unsigned NPIX = BLK_DIM * BLK_DIM,
    localparam int unsigned WPB  = NPIX / PPW,
    localparam int unsigned AW   = (WPB > 1) ? clog2(WPB) : 1,
    localparam int unsigned IW   = (NPIX > 1) ? clog2(NPIX) : 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              pix_valid_i,
    output logic              pix_ready_o,
    input  logic [PIX_W-1:0]  pix_data_i,
    input  logic              pix_sob_i,
    output logic              blk_valid_o,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [WORD_W-1:0] rd_data_o,
    input  logic              blk_ack_i,
    output logic [15:0]       blk_cnt_o,
    output logic [1:0]        err_sticky_o
);

    logic [1:0]        full_q, full_d;
    logic              wr_bank_q, rd_bank_q;
    logic [IW-1:0]     pix_idx_q, eff_idx;
    logic [AW-1:0]     wr_word_q, cur_word;
    logic [15:0]       blk_cnt_q;
    logic [1:0]        err_q;
    logic [WORD_W-1:0] rd_data_q;
    logic [WORD_W-1:0] mem_q [2*WPB];

    logic              accept, restart, blk_last, ack_ok, ack_bad;
    logic [WORD_W-1:0] asm_word;
    logic              word_done;

    assign pix_ready_o  = ~full_q[wr_bank_q];
    assign blk_valid_o  = full_q[rd_bank_q];
    assign rd_data_o    = rd_data_q;
    assign blk_cnt_o    = blk_cnt_q;
    assign err_sticky_o = err_q;

    assign accept   = pix_valid_i & pix_ready_o;
    // A start-of-block mid-block drops the partial block and restarts at pixel 0.
    assign restart  = accept & pix_sob_i & (pix_idx_q != '0);
    assign eff_idx  = restart ? '0 : pix_idx_q;
    assign cur_word = restart ? '0 : wr_word_q;
    assign blk_last = accept & (eff_idx == IW'(NPIX - 1));
    assign ack_ok   = blk_ack_i & blk_valid_o;
    assign ack_bad  = blk_ack_i & ~blk_valid_o;

    pixel_word_assembler #(
        .PIX_W (PIX_W),
        .PPW   (PPW)
    ) u_asm (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .shift_i     (accept),
        .restart_i   (restart),
        .pix_i       (pix_data_i),
        .word_o      (asm_word),
        .word_done_o (word_done)
    );

    // Completion and ack always target different banks, so both updates can apply.
    always_comb begin
        full_d = full_q;
        if (ack_ok) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (blk_last) begin
            full_d[wr_bank_q] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            pix_idx_q <= '0;
            wr_word_q <= '0;
            blk_cnt_q <= '0;
            err_q     <= '0;
            rd_data_q <= '0;
        end else begin
            full_q    <= full_d;
            rd_data_q <= mem_q[{rd_bank_q, rd_addr_i}];
            if (blk_last) begin
                wr_bank_q <= ~wr_bank_q;
                pix_idx_q <= '0;
                wr_word_q <= '0;
                blk_cnt_q <= blk_cnt_q + 16'd1;
            end else if (accept) begin
                pix_idx_q <= eff_idx + 1'b1;
                if (word_done) begin
                    wr_word_q <= cur_word + 1'b1;
                end else if (restart) begin
                    wr_word_q <= '0;
                end
            end
            if (ack_ok) begin
                rd_bank_q <= ~rd_bank_q;
            end
            if (restart) begin
                err_q[ErrSobDrop] <= 1'b1;
            end
            if (ack_bad) begin
                err_q[ErrAckEmpty] <= 1'b1;
            end
        end
    end

    // Kept free of reset so the array maps onto a simple dual-port RAM.
    always_ff @(posedge clk_i) begin
        if (word_done && !reset_i) begin
            mem_q[{wr_bank_q, cur_word}] <= asm_word;
        end
    end

endmodule

// File: tb/tb_pixel_block_buffer.sv
// Directed bench for pixel_block_buffer at default and 16-bit/4x4 parameters with a word scoreboard.
module tb_pixel_block_buffer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        pix_sob;
    logic [3:0]  rd_addr;
    logic        blk_ack;

    logic        pr_a, bv_a, pr_b, bv_b;
    logic [31:0] rd_a, rd_b;
    logic [15:0] cnt_a, cnt_b;
    logic [1:0]  err_a, err_b;

    logic        sel;
    logic        pix_ready, blk_valid;
    logic [31:0] rd_data;
    logic [15:0] blk_cnt;
    logic [1:0]  err_sticky;

    assign pix_ready  = sel ? pr_b  : pr_a;
    assign blk_valid  = sel ? bv_b  : bv_a;
    assign rd_data    = sel ? rd_b  : rd_a;
    assign blk_cnt    = sel ? cnt_b : cnt_a;
    assign err_sticky = sel ? err_b : err_a;

    pixel_block_buffer u_dut_a (
        .clk_i        (clk),
        .reset_i      (reset),
        .pix_valid_i  (pix_valid),
        .pix_ready_o  (pr_a),
        .pix_data_i   (pix_data[7:0]),
        .pix_sob_i    (pix_sob),
        .blk_valid_o  (bv_a),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_a),
        .blk_ack_i    (blk_ack),
        .blk_cnt_o    (cnt_a),
        .err_sticky_o (err_a)
    );

    pixel_block_buffer #(
        .PIX_W   (16),
        .BLK_DIM (4),
        .WORD_W  (32)
    ) u_dut_b (
        .clk_i        (clk),
        .reset_i      (reset),
        .pix_valid_i  (pix_valid),
        .pix_ready_o  (pr_b),
        .pix_data_i   (pix_data),
        .pix_sob_i    (pix_sob),
        .blk_valid_o  (bv_b),
        .rd_addr_i    (rd_addr[2:0]),
        .rd_data_o    (rd_b),
        .blk_ack_i    (blk_ack),
        .blk_cnt_o    (cnt_b),
        .err_sticky_o (err_b)
    );

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [15:0] pix_buf[64];
    int          pix_w, ppw, wpb, npix;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_pix(input logic [15:0] d, input logic sob);
        int guard = 0;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_sob   = sob;
        while (!pix_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!pix_ready) check("pix_ready_wait", 32'(pix_ready), 32'd1);
        @(negedge clk);
        pix_valid = 1'b0;
        pix_sob   = 1'b0;
    endtask

    task automatic send_buf(input int n, input logic sob_first);
        for (int i = 0; i < n; i++) send_pix(pix_buf[i], sob_first && (i == 0));
    endtask

    // Reference packing: first pixel of each word lands in the most significant bits.
    task automatic push_block();
        for (int w = 0; w < wpb; w++) begin
            logic [31:0] word = '0;
            for (int p = 0; p < ppw; p++) word = (word << pix_w) | 32'(pix_buf[w*ppw+p]);
            exp_q.push_back(word);
        end
    endtask

    task automatic read_word(input int addr, input logic [31:0] exp, input string tag);
        rd_addr = 4'(addr);
        @(negedge clk);
        check(tag, rd_data, exp);
    endtask

    task automatic read_block(input string tag);
        for (int a = 0; a < wpb; a++) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL %s scoreboard empty observed=0 expected=%0d", tag, wpb - a);
                return;
            end
            read_word(a, exp_q.pop_front(), tag);
        end
    endtask

    task automatic ack_pulse();
        blk_ack = 1'b1;
        @(negedge clk);
        blk_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b0; pix_valid = 1'b0; pix_data = '0; pix_sob = 1'b0;
        rd_addr = '0; blk_ack = 1'b0;
        sel = 1'b0; pix_w = 8; ppw = 4; wpb = 16; npix = 64;
        @(negedge clk);
        reset_dut();
        check("a_rst_ready", 32'(pix_ready), 32'd1);
        check("a_rst_valid", 32'(blk_valid), 32'd0);
        check("a_rst_rdata", rd_data, 32'd0);
        check("a_rst_cnt", 32'(blk_cnt), 32'd0);
        check("a_rst_err", 32'(err_sticky), 32'd0);

        // Single block, no ack
        for (int i = 0; i < 64; i++) pix_buf[i] = 16'(i);
        for (int i = 0; i < 63; i++) send_pix(pix_buf[i], 1'b0);
        check("a_t1_valid_early", 32'(blk_valid), 32'd0);
        send_pix(pix_buf[63], 1'b0);
        check("a_t1_valid", 32'(blk_valid), 32'd1);
        check("a_t1_cnt", 32'(blk_cnt), 32'd1);
        push_block();
        read_word(0, 32'h0001_0203, "a_t1_w0");
        read_word(15, 32'h3C3D_3E3F, "a_t1_w15");
        read_block("a_t1_blk");

        // Back-pressure with both banks full
        for (int i = 0; i < 64; i++) pix_buf[i] = 16'((i * 3 + 7) & 255);
        send_buf(64, 1'b0);
        push_block();
        check("a_t2_stall", 32'(pix_ready), 32'd0);
        check("a_t2_cnt", 32'(blk_cnt), 32'd2);
        ack_pulse();
        check("a_t2_ready_after_ack", 32'(pix_ready), 32'd1);
        check("a_t2_valid_b2", 32'(blk_valid), 32'd1);
        read_block("a_t2_b2");
        for (int i = 0; i < 64; i++) pix_buf[i] = 16'(255 - i);
        send_buf(64, 1'b0);
        push_block();
        ack_pulse();
        read_block("a_t2_b3");
        check("a_t2_cnt3", 32'(blk_cnt), 32'd3);

        // Completion of bank 1 in the same cycle bank 0 is acked
        for (int i = 0; i < 64; i++) pix_buf[i] = 16'((i * 5) & 255);
        for (int i = 0; i < 63; i++) send_pix(pix_buf[i], 1'b0);
        blk_ack = 1'b1;
        send_pix(pix_buf[63], 1'b0);
        blk_ack = 1'b0;
        push_block();
        check("a_t4_valid", 32'(blk_valid), 32'd1);
        check("a_t4_ready", 32'(pix_ready), 32'd1);
        check("a_t4_cnt", 32'(blk_cnt), 32'd4);
        check("a_t4_err", 32'(err_sticky), 32'd0);
        read_block("a_t4_blk");
        ack_pulse();

        // Mid-block start-of-block drops the partial block
        for (int i = 0; i < 20; i++) send_pix(16'(i + 100), 1'b0);
        pix_buf[0] = 16'hAA;
        for (int i = 1; i < 64; i++) pix_buf[i] = 16'(i - 1);
        send_buf(64, 1'b1);
        push_block();
        check("a_t3_err", 32'(err_sticky), 32'd1);
        check("a_t3_cnt", 32'(blk_cnt), 32'd5);
        read_word(0, 32'hAA00_0102, "a_t3_w0");
        read_block("a_t3_blk");
        ack_pulse();

        // Ack with nothing readable
        check("a_t5_valid_pre", 32'(blk_valid), 32'd0);
        ack_pulse();
        check("a_t5_err", 32'(err_sticky), 32'd3);
        check("a_t5_valid", 32'(blk_valid), 32'd0);
        check("a_t5_ready", 32'(pix_ready), 32'd1);
        check("a_t5_cnt", 32'(blk_cnt), 32'd5);

        // Reset with one bank full and another block half written
        for (int i = 0; i < 64; i++) pix_buf[i] = 16'(i ^ 8'h5A);
        send_buf(64, 1'b0);
        check("a_t6_valid_pre", 32'(blk_valid), 32'd1);
        for (int i = 0; i < 30; i++) send_pix(16'(i), 1'b0);
        reset_dut();
        exp_q.delete();
        check("a_t6_valid", 32'(blk_valid), 32'd0);
        check("a_t6_ready", 32'(pix_ready), 32'd1);
        check("a_t6_cnt", 32'(blk_cnt), 32'd0);
        check("a_t6_err", 32'(err_sticky), 32'd0);
        check("a_t6_rdata", rd_data, 32'd0);
        for (int i = 0; i < 64; i++) pix_buf[i] = 16'((i * 7 + 1) & 255);
        send_buf(64, 1'b0);
        push_block();
        check("a_t6_fresh_valid", 32'(blk_valid), 32'd1);
        check("a_t6_fresh_cnt", 32'(blk_cnt), 32'd1);
        read_block("a_t6_fresh");

        // 16-bit pixels, 4x4 blocks
        sel = 1'b1; pix_w = 16; ppw = 2; wpb = 8; npix = 16;
        exp_q.delete();
        reset_dut();
        check("b_rst_ready", 32'(pix_ready), 32'd1);
        check("b_rst_valid", 32'(blk_valid), 32'd0);
        check("b_rst_cnt", 32'(blk_cnt), 32'd0);
        check("b_rst_err", 32'(err_sticky), 32'd0);

        for (int i = 0; i < 16; i++) pix_buf[i] = 16'(i);
        for (int i = 0; i < 15; i++) send_pix(pix_buf[i], 1'b0);
        check("b_t1_valid_early", 32'(blk_valid), 32'd0);
        send_pix(pix_buf[15], 1'b0);
        check("b_t1_valid", 32'(blk_valid), 32'd1);
        check("b_t1_cnt", 32'(blk_cnt), 32'd1);
        push_block();
        read_word(0, 32'h0000_0001, "b_t1_w0");
        read_word(7, 32'h000E_000F, "b_t1_w7");
        read_block("b_t1_blk");

        for (int i = 0; i < 16; i++) pix_buf[i] = 16'(16'h100 + i * 16'h111);
        send_buf(16, 1'b0);
        push_block();
        check("b_t2_stall", 32'(pix_ready), 32'd0);
        ack_pulse();
        check("b_t2_ready_after_ack", 32'(pix_ready), 32'd1);
        read_block("b_t2_b2");
        for (int i = 0; i < 16; i++) pix_buf[i] = 16'(16'hF000 - i);
        send_buf(16, 1'b0);
        push_block();
        ack_pulse();
        read_block("b_t2_b3");
        ack_pulse();

        for (int i = 0; i < 5; i++) send_pix(16'(16'h4000 + i), 1'b0);
        pix_buf[0] = 16'hAAAA;
        for (int i = 1; i < 16; i++) pix_buf[i] = 16'(i - 1);
        send_buf(16, 1'b1);
        push_block();
        check("b_t3_err", 32'(err_sticky), 32'd1);
        read_word(0, 32'hAAAA_0000, "b_t3_w0");
        read_block("b_t3_blk");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
